// File: rtl/tick_replay_ctrl.sv
// Replay sequencer for the tick ROM: windowed, paced address issue with optional looping,
// read-valid alignment into the TLU and saturating buy/sell run statistics.
module tick_replay_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1,
    parameter int GAP_WIDTH   = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_end_addr,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic                  cfg_loop,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] tlu_data,
    output logic                  tlu_valid,
    input  logic                  buy_signal,
    input  logic                  sell_signal,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [CNT_WIDTH-1:0]  buy_count,
    output logic [CNT_WIDTH-1:0]  sell_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  start_addr_q, start_addr_d;
    logic [ADDR_WIDTH-1:0]  end_addr_q, end_addr_d;
    logic [GAP_WIDTH-1:0]   gap_cfg_q, gap_cfg_d;
    logic                   loop_q, loop_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [ROM_LATENCY-1:0] pipe_q, pipe_d;
    logic [DATA_WIDTH-1:0]  tlu_data_q, tlu_data_d;
    logic                   tlu_valid_q, tlu_valid_d;
    logic [CNT_WIDTH-1:0]   buy_q, buy_d;
    logic [CNT_WIDTH-1:0]   sell_q, sell_d;
    logic                   cfg_err_q, cfg_err_d;

    logic issue;
    logic rom_tail;
    logic drain_empty;

    // A stop in the same cycle as a due issue suppresses that issue.
    assign issue       = (state_q == ST_RUN) && (gap_cnt_q == '0) && !stop;
    assign rom_tail    = pipe_q[ROM_LATENCY-1];
    // Leave DRAIN only once the last read's tlu_valid cycle has fully passed.
    assign drain_empty = (pipe_q == '0) && !tlu_valid_q;

    assign rom_addr   = addr_q;
    assign rom_en     = issue;
    assign tlu_data   = tlu_data_q;
    assign tlu_valid  = tlu_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DRAIN) && drain_empty;
    assign cfg_err    = cfg_err_q;
    assign buy_count  = buy_q;
    assign sell_count = sell_q;

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        gap_cfg_d    = gap_cfg_q;
        loop_d       = loop_q;
        addr_d       = addr_q;
        gap_cnt_d    = gap_cnt_q;
        buy_d        = buy_q;
        sell_d       = sell_q;
        cfg_err_d    = 1'b0;

        pipe_d[0] = issue;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        tlu_valid_d = rom_tail;
        tlu_data_d  = rom_tail ? rom_data : tlu_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (cfg_start_addr > cfg_end_addr) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        start_addr_d = cfg_start_addr;
                        end_addr_d   = cfg_end_addr;
                        gap_cfg_d    = cfg_gap;
                        loop_d       = cfg_loop;
                        addr_d       = cfg_start_addr;
                        gap_cnt_d    = '0;
                        buy_d        = '0;
                        sell_d       = '0;
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (gap_cnt_q == '0) begin
                    gap_cnt_d = gap_cfg_q;
                    if (addr_q == end_addr_q) begin
                        if (loop_q) begin
                            addr_d = start_addr_q;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counting covers the done cycle too, since the state is still DRAIN then.
        if (state_q != ST_IDLE) begin
            if (buy_signal && (buy_q != '1)) begin
                buy_d = buy_q + CNT_WIDTH'(1);
            end
            if (sell_signal && (sell_q != '1)) begin
                sell_d = sell_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            gap_cfg_q    <= '0;
            loop_q       <= 1'b0;
            addr_q       <= '0;
            gap_cnt_q    <= '0;
            pipe_q       <= '0;
            tlu_data_q   <= '0;
            tlu_valid_q  <= 1'b0;
            buy_q        <= '0;
            sell_q       <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            gap_cfg_q    <= gap_cfg_d;
            loop_q       <= loop_d;
            addr_q       <= addr_d;
            gap_cnt_q    <= gap_cnt_d;
            pipe_q       <= pipe_d;
            tlu_data_q   <= tlu_data_d;
            tlu_valid_q  <= tlu_valid_d;
            buy_q        <= buy_d;
            sell_q       <= sell_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_tick_replay_ctrl.sv
// Scoreboard bench for tick_replay_ctrl: stimulus queues expected issues and tick bytes,
// a negedge monitor checks each ROM issue, TLU delivery and done pulse as it appears.
module tb_tick_replay_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [15:0] cfg_start_addr, cfg_end_addr;
    logic [7:0]  cfg_gap;
    logic        cfg_loop;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data;
    logic [7:0]  tlu_data;
    logic        tlu_valid;
    logic        buy_signal, sell_signal;
    logic        busy, done, cfg_err;
    logic [1:0]  buy_count, sell_count;

    tick_replay_ctrl #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .ROM_LATENCY(1), .GAP_WIDTH(8), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
        .cfg_gap(cfg_gap), .cfg_loop(cfg_loop),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .tlu_data(tlu_data), .tlu_valid(tlu_valid),
        .buy_signal(buy_signal), .sell_signal(sell_signal),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .buy_count(buy_count), .sell_count(sell_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [15:0] a);
        return a[7:0] * 8'd5 + a[15:8] + 8'h1B;
    endfunction

    // Single-cycle-latency ROM model
    always @(posedge clk) rom_data <= rom_f(rom_addr);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0, valid_cnt = 0, done_cnt = 0, err_cnt = 0;
    int exp_gap = 1;
    int have_last = 0, last_issue = 0;
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    int          pend_q[$];
    int i0, v0, d0, e0, n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every DUT presentation against the queued expectations
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (!busy) have_last = 0;
            if (rom_en) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_issue", {48'd0, rom_addr}, 64'hFFFF_FFFF);
                end else begin
                    chk("issue_addr", rom_addr, exp_addr_q.pop_front());
                end
                if (have_last != 0) chk("issue_spacing", cyc - last_issue, exp_gap);
                have_last = 1;
                last_issue = cyc;
                pend_q.push_back(cyc);
                issue_cnt++;
            end
            if (tlu_valid) begin
                valid_cnt++;
                if (exp_data_q.size() == 0 || pend_q.size() == 0) begin
                    chk("unexpected_tlu_valid", {56'd0, tlu_data}, 64'hFFFF_FFFF);
                end else begin
                    chk("tlu_data", tlu_data, exp_data_q.pop_front());
                    chk("tlu_latency", cyc - pend_q.pop_front(), 2);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_with_busy", busy, 1);
                chk("done_after_last_valid", pend_q.size(), 0);
            end
            if (cfg_err) err_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] s, input logic [15:0] e, input logic [7:0] g,
                           input logic l);
        cfg_start_addr = s;
        cfg_end_addr   = e;
        cfg_gap        = g;
        cfg_loop       = l;
    endtask

    task automatic push_run(input logic [15:0] first, input int cnt);
        logic [15:0] a;
        for (int k = 0; k < cnt; k++) begin
            a = first + 16'(k);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(rom_f(a));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc1();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d_start;
        int w;
        d_start = done_cnt;
        w = 0;
        while (done_cnt == d_start && w < budget) begin
            cyc1();
            w++;
        end
        chk(name, done_cnt - d_start, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_tlu_valid"}, tlu_valid, 0);
        chk({tag, "_tlu_data"}, tlu_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_buy_count"}, buy_count, 0);
        chk({tag, "_sell_count"}, sell_count, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        buy_signal = 1'b0; sell_signal = 1'b0;
        set_cfg(16'h0, 16'h0, 8'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        cyc1();

        // Basic window, back-to-back issues
        set_cfg(16'h0010, 16'h0013, 8'd0, 1'b0);
        exp_gap = 1; push_run(16'h0010, 4);
        i0 = issue_cnt; v0 = valid_cnt;
        pulse_start();
        wait_done("t1_done", 40);
        chk("t1_issues", issue_cnt - i0, 4);
        chk("t1_valids", valid_cnt - v0, 4);
        chk("t1_busy_after", busy, 0);
        cyc1();
        chk("t1_tlu_data_hold", tlu_data, rom_f(16'h0013));

        // Looping with pacing, stopped after the 5th issue
        set_cfg(16'h0000, 16'h0001, 8'd3, 1'b1);
        exp_gap = 4;
        for (int k = 0; k < 5; k++) begin
            exp_addr_q.push_back(16'(k % 2));
            exp_data_q.push_back(rom_f(16'(k % 2)));
        end
        i0 = issue_cnt; v0 = valid_cnt; n = 0;
        pulse_start();
        while (issue_cnt - i0 < 5 && n < 60) begin
            cyc1();
            n++;
        end
        stop = 1'b1;
        cyc1();
        stop = 1'b0;
        wait_done("t2_done", 40);
        chk("t2_issues", issue_cnt - i0, 5);
        chk("t2_valids", valid_cnt - v0, 5);
        chk("t2_busy_after", busy, 0);

        // start and stop together in IDLE: nothing happens
        set_cfg(16'h0020, 16'h0021, 8'd0, 1'b0);
        e0 = err_cnt; i0 = issue_cnt;
        start = 1'b1; stop = 1'b1;
        cyc1();
        start = 1'b0; stop = 1'b0;
        chk("t4_startstop_busy", busy, 0);
        repeat (3) cyc1();
        chk("t4_startstop_busy_later", busy, 0);
        chk("t4_startstop_issues", issue_cnt - i0, 0);
        chk("t4_startstop_cfg_err", err_cnt - e0, 0);

        // Mid-run restart and config changes are ignored
        set_cfg(16'h0030, 16'h0033, 8'd2, 1'b0);
        exp_gap = 3; push_run(16'h0030, 4);
        i0 = issue_cnt;
        pulse_start();
        cyc1();
        set_cfg(16'h0031, 16'h0031, 8'd0, 1'b1);
        pulse_start();
        wait_done("t4_midrun_done", 60);
        chk("t4_midrun_issues", issue_cnt - i0, 4);

        // Stop coinciding with a due issue suppresses it
        set_cfg(16'h0040, 16'h004F, 8'd0, 1'b1);
        exp_gap = 1; push_run(16'h0040, 2);
        i0 = issue_cnt; v0 = valid_cnt;
        pulse_start();
        repeat (2) cyc1();
        stop = 1'b1;
        cyc1();
        stop = 1'b0;
        wait_done("t4_stop_done", 20);
        chk("t4_stop_issues", issue_cnt - i0, 2);
        chk("t4_stop_valids", valid_cnt - v0, 2);

        // Counter saturation at 3 with a 2-bit counter
        set_cfg(16'h0050, 16'h005F, 8'd0, 1'b0);
        exp_gap = 1; push_run(16'h0050, 16);
        pulse_start();
        buy_signal = 1'b1; sell_signal = 1'b1;
        repeat (2) cyc1();
        sell_signal = 1'b0;
        repeat (4) cyc1();
        buy_signal = 1'b0;
        wait_done("t5_done", 60);
        chk("t5_buy_saturated", buy_count, 3);
        chk("t5_sell_count", sell_count, 2);

        // Rejected start: cfg_err pulse, counters untouched
        set_cfg(16'h0020, 16'h001F, 8'd0, 1'b0);
        e0 = err_cnt; i0 = issue_cnt;
        pulse_start();
        chk("t3_cfg_err_pulse", cfg_err, 1);
        cyc1();
        chk("t3_cfg_err_clear", cfg_err, 0);
        chk("t3_busy", busy, 0);
        chk("t3_err_count", err_cnt - e0, 1);
        chk("t3_issues", issue_cnt - i0, 0);
        chk("t3_buy_kept", buy_count, 3);
        chk("t3_sell_kept", sell_count, 2);

        // Accepted start clears counters; reset lands with two reads in flight
        set_cfg(16'h0060, 16'h006F, 8'd0, 1'b0);
        exp_gap = 1;
        exp_addr_q.push_back(16'h0060);
        exp_addr_q.push_back(16'h0061);
        pulse_start();
        chk("t6_buy_cleared", buy_count, 0);
        chk("t6_sell_cleared", sell_count, 0);
        repeat (2) cyc1();
        rst = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        chk("t6_issued_before_rst", exp_addr_q.size(), 0);
        pend_q.delete();
        exp_data_q.delete();
        repeat (2) cyc1();
        rst = 1'b0;
        d0 = done_cnt; v0 = valid_cnt;
        repeat (6) cyc1();
        chk("t6_no_valid_after_rst", valid_cnt - v0, 0);
        chk("t6_no_done_after_rst", done_cnt - d0, 0);
        chk("t6_idle_after_rst", busy, 0);

        set_cfg(16'h0070, 16'h0072, 8'd1, 1'b0);
        exp_gap = 2; push_run(16'h0070, 3);
        i0 = issue_cnt; v0 = valid_cnt;
        pulse_start();
        wait_done("t6_fresh_done", 40);
        chk("t6_fresh_issues", issue_cnt - i0, 3);
        chk("t6_fresh_valids", valid_cnt - v0, 3);

        cyc1();
        chk("final_addr_queue_empty", exp_addr_q.size(), 0);
        chk("final_data_queue_empty", exp_data_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
